// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2,
        RAMP  = 2'd3
    } sched_state_e;

    localparam logic [7:0] DAC_MIDSCALE = 8'd128;
    localparam int         UNDERRUN_W   = 16;

    // One LSB toward target, never past it.
    function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] target);
        if (cur < target) return cur + 8'd1;
        if (cur > target) return cur - 8'd1;
        return cur;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with a registered head word.
// Latency: pushed word visible at head one clk after push into an empty FIFO.
// Backpressure: push ignored while full, pop ignored while empty.
module sync_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [1 << AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic          do_push;
    logic          do_pop;

    assign full       = (level == DEPTH);
    assign empty      = (level == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_nxt;
            if (do_push && !do_pop)      level <= level + (AW+1)'(1);
            else if (do_pop && !do_push) level <= level - (AW+1)'(1);
            // Bypass when the slot being written becomes the new head.
            head <= (do_push && (wr_ptr == rd_ptr_nxt)) ? push_dat : mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/dac_sample_sched.sv
// Buffers upstream samples and releases one per sample tick to the PWM DAC; ramps to midscale on stop.
// Latency: sample and sample_strobe update 1 clk after the tick cycle.
// Backpressure: s_ready = !full from registered state; no pop on empty, underrun counted instead.
module dac_sample_sched
    import dac_sched_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 1024,
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned PRIME_LVL = 8,
    parameter logic [7:0]  MIDSCALE  = DAC_MIDSCALE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [7:0]            sample,
    output logic                  sample_strobe,
    output logic [FIFO_AW:0]      fifo_level,
    output logic [UNDERRUN_W-1:0] underrun_cnt,
    output logic                  busy
);

    localparam logic [15:0]           DIV_LAST     = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0]      PRIME_THR    = (FIFO_AW+1)'(PRIME_LVL);
    localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = '1;

    sched_state_e state;
    sched_state_e state_nxt;
    logic [15:0]  div_cnt;
    logic         tick;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [7:0]   head;
    logic [7:0]   sample_nxt;
    logic         strobe_nxt;
    logic         underrun_inc;

    assign s_ready = !fifo_full;
    assign busy    = (state != IDLE);
    assign tick    = (state != IDLE) && (div_cnt == DIV_LAST);

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s_valid && s_ready),
        .push_dat (s_data),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Stop requests override tick actions in every playing state.
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        sample_nxt   = sample;
        strobe_nxt   = 1'b0;
        underrun_inc = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = PRIME;
            end
            PRIME: begin
                if (!enable)                       state_nxt = RAMP;
                else if (fifo_level >= PRIME_THR)  state_nxt = PLAY;
            end
            PLAY: begin
                if (!enable) begin
                    state_nxt = RAMP;
                end else if (tick) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        sample_nxt = head;
                        strobe_nxt = 1'b1;
                    end else begin
                        underrun_inc = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (enable) begin
                    state_nxt = PRIME;
                end else if (sample == MIDSCALE) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    sample_nxt = ramp_step(sample, MIDSCALE);
                    strobe_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt       <= '0;
            sample        <= MIDSCALE;
            sample_strobe <= 1'b0;
            underrun_cnt  <= '0;
        end else begin
            if (state == IDLE || state_nxt == IDLE || tick) div_cnt <= '0;
            else                                            div_cnt <= div_cnt + 16'd1;
            sample        <= sample_nxt;
            sample_strobe <= strobe_nxt;
            if (underrun_inc && underrun_cnt != UNDERRUN_MAX)
                underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
        end
    end

endmodule

// File: tb/tb_dac_sample_sched.sv
// Directed-sequence bench with random sample data for dac_sample_sched (CLK_DIV=8, depth 16, prime 4).
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            failures++; \
            $error("FAIL %s observed=%0d expected=%0d", tag, (obs), (exp)); \
        end \
    end

module tb_dac_sample_sched;

    localparam int         CLK_DIV   = 8;
    localparam int         FIFO_AW   = 4;
    localparam int         DEPTH     = 16;
    localparam int         PRIME_LVL = 4;
    localparam logic [7:0] MID       = 8'd128;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       sample;
    logic             sample_strobe;
    logic [FIFO_AW:0] fifo_level;
    logic [15:0]      underrun_cnt;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] v [5];
    logic [7:0] d [17];
    logic [7:0] prev;
    logic       exp_acc;
    int         dd, t, acc, idx, nstrobe, bad, n;

    always #5 clk = ~clk;

    dac_sample_sched #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_AW   (FIFO_AW),
        .PRIME_LVL (PRIME_LVL),
        .MIDSCALE  (MID)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .sample        (sample),
        .sample_strobe (sample_strobe),
        .fifo_level    (fifo_level),
        .underrun_cnt  (underrun_cnt),
        .busy          (busy)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] toward_mid(input logic [7:0] x);
        return (x < MID) ? x + 8'd1 : x - 8'd1;
    endfunction

    // While ramping, every strobe is one LSB closer to midscale; otherwise sample holds.
    task automatic ramp_mon();
        if (sample_strobe) begin
            prev = toward_mid(prev);
            `CHK("ramp_step", sample, prev)
        end else begin
            `CHK("ramp_hold", sample, prev)
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = 8'd0;
        @(negedge clk);
        step();
        `CHK("rst_sample", sample, MID)
        `CHK("rst_strobe", sample_strobe, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_ready", s_ready, 1'b1)
        `CHK("rst_level", fifo_level, 5'd0)
        `CHK("rst_underrun", underrun_cnt, 16'd0)
        rst = 1'b0;

        nstrobe = 0; bad = 0;
        repeat (50) begin
            step();
            if (sample_strobe !== 1'b0) nstrobe++;
            if (sample !== MID || busy !== 1'b0 || s_ready !== 1'b1) bad++;
        end
        `CHK("idle_strobes", nstrobe, 0)
        `CHK("idle_outputs", bad, 0)

        // Prime with 5 random samples, play them out, then run dry for 3 ticks.
        foreach (v[i]) v[i] = 8'($urandom_range(0, 255));
        enable = 1'b1;
        for (int e = 1; e <= 65; e++) begin
            if (e <= 5) begin s_valid = 1'b1; s_data = v[e-1]; end
            else        s_valid = 1'b0;
            step();
            dd = e - 1;
            if (dd > 0 && dd % CLK_DIV == 0) begin
                t = dd / CLK_DIV;
                if (t <= 5) begin
                    `CHK("play_strobe", sample_strobe, 1'b1)
                    `CHK("play_sample", sample, v[t-1])
                end else begin
                    `CHK("underrun_strobe", sample_strobe, 1'b0)
                    `CHK("underrun_hold", sample, v[4])
                    `CHK("underrun_cnt", underrun_cnt, 16'(t - 5))
                end
            end else begin
                `CHK("play_no_strobe", sample_strobe, 1'b0)
            end
        end
        `CHK("play_busy", busy, 1'b1)
        `CHK("play_empty", fifo_level, 5'd0)

        // Stop and overfill while the output ramps back to midscale.
        d[0] = 8'd125; d[1] = 8'd200;
        for (int i = 2; i < 17; i++) d[i] = 8'($urandom_range(0, 255));
        enable = 1'b0; prev = v[4]; acc = 0; idx = 0;
        for (int c = 0; c < 22; c++) begin
            s_valid = 1'b1; s_data = d[idx];
            exp_acc = (acc < DEPTH);
            `CHK("fill_ready", s_ready, exp_acc)
            `CHK("fill_level", fifo_level, 5'(acc))
            step();
            ramp_mon();
            if (exp_acc) begin acc++; idx++; end
        end
        `CHK("full_level", fifo_level, 5'd16)
        `CHK("full_ready", s_ready, 1'b0)
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            step();
            ramp_mon();
            n++;
        end
        `CHK("stop_idle", busy, 1'b0)
        `CHK("stop_sample", sample, MID)
        `CHK("stop_fifo_kept", fifo_level, 5'd16)
        `CHK("stop_underrun_kept", underrun_cnt, 16'd3)

        // Play 125 from a full FIFO, the pending 17th word enters after that pop, then stop.
        enable = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            step();
            dd = e - 1;
            if (dd == CLK_DIV) begin
                `CHK("p125_strobe", sample_strobe, 1'b1)
                `CHK("p125_sample", sample, 8'd125)
                `CHK("p125_level", fifo_level, 5'd15)
                `CHK("p125_ready", s_ready, 1'b1)
                enable = 1'b0;
            end else if (dd == CLK_DIV + 1) begin
                `CHK("refill_level", fifo_level, 5'd16)
                s_valid = 1'b0;
            end else if (dd > CLK_DIV && dd % CLK_DIV == 0) begin
                `CHK("ramp_strobe", sample_strobe, 1'b1)
                `CHK("ramp_value", sample, 8'(126 + dd / CLK_DIV - 2))
            end else if (dd > CLK_DIV) begin
                `CHK("ramp_no_strobe", sample_strobe, 1'b0)
            end
        end
        `CHK("ramp_end_idle", busy, 1'b0)
        `CHK("ramp_end_sample", sample, MID)
        `CHK("ramp_end_fifo", fifo_level, 5'd16)

        // Reset in the middle of playback at sample 200.
        enable = 1'b1;
        repeat (CLK_DIV + 1) step();
        `CHK("p200_strobe", sample_strobe, 1'b1)
        `CHK("p200_sample", sample, 8'd200)
        rst = 1'b1; enable = 1'b0;
        step();
        rst = 1'b0;
        `CHK("mid_rst_sample", sample, MID)
        `CHK("mid_rst_level", fifo_level, 5'd0)
        `CHK("mid_rst_underrun", underrun_cnt, 16'd0)
        `CHK("mid_rst_busy", busy, 1'b0)
        `CHK("mid_rst_strobe", sample_strobe, 1'b0)
        `CHK("mid_rst_ready", s_ready, 1'b1)
        step();
        `CHK("post_rst_sample", sample, MID)
        `CHK("post_rst_busy", busy, 1'b0)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
